pong_ball_engine: RTL and testbench
===================================

# pong_ball_engine

Parametrised ball-physics and scoring engine for the pong design, generalising the free-running ball mover. Advances the ball once per game tick. Reflects the ball off the top and bottom walls and off both paddles, accelerating on each paddle hit. Detects misses, keeps both scores, and runs a serve/play/game-over state machine. It sits between paddle_control (paddle positions in) and vga_controller (ball position out).

## Interface
- H_RES, 640: field width in pixels.
- V_RES, 480: field height in pixels.
- BALL_SIZE, 8: ball square edge in pixels.
- PADDLE_W, 8: paddle width in pixels.
- PADDLE_H, 64: paddle height in pixels.
- PADDLE_L_X, 16: left paddle left edge x.
- PADDLE_R_X, 616: right paddle left edge x.
- VY, 1: vertical step in pixels per tick.
- MAX_SPEED, 6: maximum horizontal step in pixels per tick; minimum is 1.
- SERVE_TICKS, 60: ticks the ball rests at centre before each serve.
- WIN_SCORE, 7: score that ends the game.
- SCORE_W, 4: score counter width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle game-step strobe.
- start  in  1  begins a new game; level or pulse, sampled every cycle.
- paddleL_y  in  10  left paddle top y.
- paddleR_y  in  10  right paddle top y.
- ball_x  out  10  ball left edge.
- ball_y  out  10  ball top edge.
- scoreL  out  SCORE_W  left player score.
- scoreR  out  SCORE_W  right player score.
- state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3.
- winner  out  2  0 none, 1 left, 2 right.
- hit_pulse  out  1  one cycle on a paddle bounce.
- score_pulse  out  1  one cycle on a point.

## Operation
- Reset values:
  - state=IDLE; ball_x=CX=(H_RES-BALL_SIZE)/2 (316); ball_y=CY=(V_RES-BALL_SIZE)/2 (236).
  - Scores 0, winner 0, both pulses 0.
  - Internal: speed sx=1, dir_x=right, dir_y=down, serve counter 0.
- IDLE or OVER:
  - start=1 → SERVE.
  - Scores, winner, serve counter, sx and dir_y are reset to their reset values, and dir_x=right.
  - The ball is centred.
- SERVE:
  - The ball is held at (CX,CY) and the serve counter increments on each tick.
  - On the tick where the counter reaches SERVE_TICKS-1 → PLAY. The counter is cleared; the ball does not move on that tick.
  - start is ignored.
- PLAY, evaluated on each tick. Arithmetic is 11-bit unsigned so no intermediate value wraps.
  - Vertical, moving up: if y ≤ VY, then y'=0 and dir_y=down; else y'=y−VY.
  - Vertical, moving down: if y+VY ≥ V_RES−BALL_SIZE, then y'=V_RES−BALL_SIZE and dir_y=up; else y'=y+VY.
  - Overlap L is true when y+BALL_SIZE > paddleL_y and y < paddleL_y+PADDLE_H, using the current y. Overlap R is defined the same way.
  - Left hit: dir_x=left, x ≥ PADDLE_L_X+PADDLE_W, x−sx ≤ PADDLE_L_X+PADDLE_W (11-bit signed compare) and overlap L.
    - Then x'=PADDLE_L_X+PADDLE_W, dir_x=right, sx=min(sx+1,MAX_SPEED), hit_pulse.
  - Right hit: dir_x=right, x+BALL_SIZE ≤ PADDLE_R_X, x+sx+BALL_SIZE ≥ PADDLE_R_X and overlap R.
    - Then x'=PADDLE_R_X−BALL_SIZE, dir_x=left, sx incremented as above, hit_pulse.
  - Left miss: no hit, dir_x=left and x ≤ sx.
    - scoreR+1, score_pulse, dir_x=left so the serve goes toward the conceding player, sx=1, dir_y=down, ball centred.
  - Right miss: the mirror of left miss, with the test x+sx ≥ H_RES−BALL_SIZE. Increments scoreL.
  - Otherwise: x'=x±sx.
  - After a point: if the incremented score equals WIN_SCORE → OVER with winner set; else → SERVE.
- Priority and simultaneous events:
  - A paddle hit beats a miss.
  - Wall and paddle reflections in the same tick both apply.
  - A score never exceeds WIN_SCORE.
- Non-tick cycles change nothing except start handling in IDLE/OVER.
- rst asserted in any state, including mid-PLAY, returns all outputs to reset values on the next edge.

## Timing
- All outputs are registered.
- Tick sampled high at edge N → updated ball_x/ball_y/scores/state visible after edge N.
- hit_pulse and score_pulse are high for exactly the cycle following edge N.
- start sampled at edge N in IDLE/OVER → state=SERVE after edge N.
- Serve length: exactly SERVE_TICKS ticks in SERVE, then the first move happens on the next tick.
- Back-to-back ticks (tick held high) advance one step per cycle.

## Test plan
- Reset, then no start for 1000 ticks → state=0, ball (316,236), scores 0, no pulses.
- start pulse; SERVE_TICKS=4 → PLAY after the 4th tick. The first PLAY tick gives ball (317,237) with sx=1, moving right and down.
- Ball at y=2 moving up, VY=3 → y'=0, dir_y flips. The next tick gives y=3.
- Left paddle at y=100, ball (25,120) moving left with sx=2 → x'=24, hit_pulse for 1 cycle, sx=3, then moving right.
- Left paddle at y=300, ball (1,120) moving left with sx=1 → scoreR=1, score_pulse, ball (316,236), state=SERVE.
- scoreL=6, right miss → scoreL=7, state=3, winner=1. A later start gives scores 0 and state=1. rst asserted mid-PLAY → state=0 on the next cycle.

Source files
------------

// File: rtl/pong_ball_engine_if.sv
// Signal bundle between the pong ball engine and its neighbours:
// paddle positions and game strobes in, ball position, scores and events out.
interface pong_ball_engine_if #(
  parameter int SCORE_W = 4
);
  logic               tick;
  logic               start;
  logic [9:0]         paddleL_y;
  logic [9:0]         paddleR_y;
  logic [9:0]         ball_x;
  logic [9:0]         ball_y;
  logic [SCORE_W-1:0] scoreL;
  logic [SCORE_W-1:0] scoreR;
  logic [1:0]         state;
  logic [1:0]         winner;
  logic               hit_pulse;
  logic               score_pulse;

  modport master (
    output tick, start, paddleL_y, paddleR_y,
    input  ball_x, ball_y, scoreL, scoreR, state, winner, hit_pulse, score_pulse
  );

  modport slave (
    input  tick, start, paddleL_y, paddleR_y,
    output ball_x, ball_y, scoreL, scoreR, state, winner, hit_pulse, score_pulse
  );
endinterface

// File: rtl/pong_ball_engine.sv
// Ball physics and scoring for pong: wall/paddle reflection with speed-up,
// miss detection, two scores and an IDLE/SERVE/PLAY/OVER game state machine.
module pong_ball_engine #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_L_X  = 16,
  parameter int PADDLE_R_X  = 616,
  parameter int VY          = 1,
  parameter int MAX_SPEED   = 6,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  pong_ball_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_e;

  localparam int SX_W  = $clog2(MAX_SPEED + 1);
  localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [10:0] CX     = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic [10:0] CY     = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0] X_MAX  = 11'(H_RES - BALL_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0] L_FACE = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0] R_FACE = 11'(PADDLE_R_X);
  localparam logic [10:0] R_STOP = 11'(PADDLE_R_X - BALL_SIZE);
  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] PH     = 11'(PADDLE_H);
  localparam logic [10:0] VY11   = 11'(VY);

  state_e             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic [SX_W-1:0]    sx_q, sx_d, sx_inc_w;
  logic               dir_x_q, dir_x_d;   // 1 = right
  logic               dir_y_q, dir_y_d;   // 1 = down
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [SCORE_W-1:0] score_l_inc_w, score_r_inc_w;
  logic [1:0]         winner_q, winner_d;
  logic               hit_q, hit_d, spulse_q, spulse_d;

  logic [10:0] x_w, y_w, sx_w, pl_w, pr_w;
  logic [9:0]  ny_w;
  logic        ndy_w, ovl_w, ovr_w, hit_l_w, hit_r_w, miss_l_w, miss_r_w;

  // Collision geometry for the current ball position and paddle positions.
  always_comb begin
    x_w  = {1'b0, x_q};
    y_w  = {1'b0, y_q};
    sx_w = 11'(sx_q);
    pl_w = {1'b0, bus.paddleL_y};
    pr_w = {1'b0, bus.paddleR_y};
    ovl_w = (y_w + BS > pl_w) && (y_w < pl_w + PH);
    ovr_w = (y_w + BS > pr_w) && (y_w < pr_w + PH);
    if (dir_y_q) begin
      if (y_w + VY11 >= Y_MAX) begin
        ny_w  = Y_MAX[9:0];
        ndy_w = 1'b0;
      end else begin
        ny_w  = 10'(y_w + VY11);
        ndy_w = 1'b1;
      end
    end else begin
      if (y_w <= VY11) begin
        ny_w  = 10'd0;
        ndy_w = 1'b1;
      end else begin
        ny_w  = 10'(y_w - VY11);
        ndy_w = 1'b0;
      end
    end
    // Signed compare: the step may carry the ball past the paddle face.
    hit_l_w  = !dir_x_q && (x_w >= L_FACE) && ($signed(x_w - sx_w) <= $signed(L_FACE)) && ovl_w;
    hit_r_w  = dir_x_q && (x_w + BS <= R_FACE) && (x_w + sx_w + BS >= R_FACE) && ovr_w;
    miss_l_w = !hit_l_w && !dir_x_q && (x_w <= sx_w);
    miss_r_w = !hit_r_w && dir_x_q && (x_w + sx_w >= X_MAX);
    sx_inc_w      = (sx_q < SX_W'(MAX_SPEED)) ? sx_q + SX_W'(1) : sx_q;
    score_l_inc_w = score_l_q + SCORE_W'(1);
    score_r_inc_w = score_r_q + SCORE_W'(1);
  end

  // Game state machine and ball update.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sx_d      = sx_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    cnt_d     = cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    hit_d     = 1'b0;
    spulse_d  = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        x_d = CX[9:0];
        y_d = CY[9:0];
        if (bus.start) begin
          state_d   = SERVE;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = 2'd0;
          cnt_d     = '0;
          sx_d      = SX_W'(1);
          dir_x_d   = 1'b1;
          dir_y_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      SERVE: begin
        x_d = CX[9:0];
        y_d = CY[9:0];
        if (bus.tick) begin
          if (cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      PLAY: begin
        if (bus.tick) begin
          y_d     = ny_w;
          dir_y_d = ndy_w;
          if (hit_l_w) begin
            x_d     = L_FACE[9:0];
            dir_x_d = 1'b1;
            sx_d    = sx_inc_w;
            hit_d   = 1'b1;
          end else if (hit_r_w) begin
            x_d     = R_STOP[9:0];
            dir_x_d = 1'b0;
            sx_d    = sx_inc_w;
            hit_d   = 1'b1;
          end else if (miss_l_w || miss_r_w) begin
            // Re-serve toward whoever conceded the point.
            x_d      = CX[9:0];
            y_d      = CY[9:0];
            dir_x_d  = miss_r_w;
            dir_y_d  = 1'b1;
            sx_d     = SX_W'(1);
            spulse_d = 1'b1;
            state_d  = SERVE;
            if (miss_l_w) begin
              score_r_d = score_r_inc_w;
              if (score_r_inc_w == SCORE_W'(WIN_SCORE)) begin
                state_d  = OVER;
                winner_d = 2'd2;
              end else begin
                winner_d = 2'd0;
              end
            end else begin
              score_l_d = score_l_inc_w;
              if (score_l_inc_w == SCORE_W'(WIN_SCORE)) begin
                state_d  = OVER;
                winner_d = 2'd1;
              end else begin
                winner_d = 2'd0;
              end
            end
          end else begin
            x_d = dir_x_q ? 10'(x_w + sx_w) : 10'(x_w - sx_w);
          end
        end else begin
          state_d = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= CX[9:0];
      y_q       <= CY[9:0];
      sx_q      <= SX_W'(1);
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      cnt_q     <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= 2'd0;
      hit_q     <= 1'b0;
      spulse_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sx_q      <= sx_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      cnt_q     <= cnt_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
      hit_q     <= hit_d;
      spulse_q  <= spulse_d;
    end
  end

  assign bus.ball_x      = x_q;
  assign bus.ball_y      = y_q;
  assign bus.scoreL      = score_l_q;
  assign bus.scoreR      = score_r_q;
  assign bus.state       = state_q;
  assign bus.winner      = winner_q;
  assign bus.hit_pulse   = hit_q;
  assign bus.score_pulse = spulse_q;
endmodule

// File: tb/tb_pong_ball_engine.sv
// Scoreboard bench for pong_ball_engine: a behavioural model predicts every
// registered output per cycle; scenario tasks add directed checks.
module tb_pong_ball_engine;
  localparam int H_RES = 640, V_RES = 480, BALL = 8, PW = 8, PH = 64;
  localparam int PLX = 16, PRX = 616, VY = 3, MAXS = 6, ST = 4, WIN = 7;
  localparam int CX = (H_RES - BALL) / 2, CY = (V_RES - BALL) / 2, LF = PLX + PW;

  logic clk, rst;
  pong_ball_engine_if #(.SCORE_W(4)) bus();

  pong_ball_engine #(
    .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(BALL), .PADDLE_W(PW), .PADDLE_H(PH),
    .PADDLE_L_X(PLX), .PADDLE_R_X(PRX), .VY(VY), .MAX_SPEED(MAXS),
    .SERVE_TICKS(ST), .WIN_SCORE(WIN), .SCORE_W(4)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [33:0] obs_w;
  assign obs_w = {bus.state, bus.ball_x, bus.ball_y, bus.scoreL, bus.scoreR,
                  bus.winner, bus.hit_pulse, bus.score_pulse};

  logic [33:0] sb[$];
  logic [33:0] exp_v;
  int n_checks = 0, n_fail = 0;
  int m_state, m_x, m_y, m_sx, m_dx, m_dy, m_cnt, m_sl, m_sr, m_win, m_hits = 0;
  bit m_hit, m_sp;

  // Reference model: advance one clock edge and queue the expected outputs.
  task automatic model_step(input logic r, input logic t, input logic s, input int pl, input int pr);
    int ny, ndy;
    bit ovl, ovr, lhit, rhit;
    m_hit = 0; m_sp = 0;
    if (r) begin
      m_state = 0; m_x = CX; m_y = CY; m_sx = 1; m_dx = 1; m_dy = 1;
      m_cnt = 0; m_sl = 0; m_sr = 0; m_win = 0;
    end else if (m_state == 0 || m_state == 3) begin
      if (s) begin
        m_state = 1; m_sl = 0; m_sr = 0; m_win = 0; m_cnt = 0;
        m_sx = 1; m_dx = 1; m_dy = 1; m_x = CX; m_y = CY;
      end
    end else if (m_state == 1) begin
      if (t) begin
        if (m_cnt == ST - 1) begin m_cnt = 0; m_state = 2; end
        else m_cnt++;
      end
    end else if (t) begin
      if (m_dy == 0) begin
        if (m_y <= VY) begin ny = 0; ndy = 1; end else begin ny = m_y - VY; ndy = 0; end
      end else begin
        if (m_y + VY >= V_RES - BALL) begin ny = V_RES - BALL; ndy = 0; end
        else begin ny = m_y + VY; ndy = 1; end
      end
      ovl  = (m_y + BALL > pl) && (m_y < pl + PH);
      ovr  = (m_y + BALL > pr) && (m_y < pr + PH);
      lhit = (m_dx == 0) && (m_x >= LF) && (m_x - m_sx <= LF) && ovl;
      rhit = (m_dx == 1) && (m_x + BALL <= PRX) && (m_x + m_sx + BALL >= PRX) && ovr;
      m_y = ny; m_dy = ndy;
      if (lhit) begin
        m_x = LF; m_dx = 1; m_sx = (m_sx + 1 > MAXS) ? MAXS : m_sx + 1; m_hit = 1; m_hits++;
      end else if (rhit) begin
        m_x = PRX - BALL; m_dx = 0; m_sx = (m_sx + 1 > MAXS) ? MAXS : m_sx + 1; m_hit = 1; m_hits++;
      end else if (m_dx == 0 && m_x <= m_sx) begin
        m_sr++; m_sp = 1; m_dx = 0; m_sx = 1; m_dy = 1; m_x = CX; m_y = CY;
        if (m_sr == WIN) begin m_state = 3; m_win = 2; end else m_state = 1;
      end else if (m_dx == 1 && m_x + m_sx >= H_RES - BALL) begin
        m_sl++; m_sp = 1; m_dx = 1; m_sx = 1; m_dy = 1; m_x = CX; m_y = CY;
        if (m_sl == WIN) begin m_state = 3; m_win = 1; end else m_state = 1;
      end else begin
        m_x = (m_dx == 1) ? m_x + m_sx : m_x - m_sx;
      end
    end
    sb.push_back({2'(m_state), 10'(m_x), 10'(m_y), 4'(m_sl), 4'(m_sr), 2'(m_win), m_hit, m_sp});
  endtask

  task automatic cycle(input logic t, input logic s, input logic r);
    bus.tick = t; bus.start = s; rst = r;
    model_step(r, t, s, int'(bus.paddleL_y), int'(bus.paddleR_y));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit pulse_seen = 0;
    bus.paddleL_y = 10'd100; bus.paddleR_y = 10'd100;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_w !== exp_v) begin n_fail++; $display("FAIL reset_sb: got %h want %h", obs_w, exp_v); end
    end
    n_checks++;
    if (bus.state !== 2'd0 || bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236 ||
        bus.scoreL !== 4'd0 || bus.scoreR !== 4'd0 || bus.winner !== 2'd0) begin
      n_fail++; $display("FAIL reset_vals: got %h", obs_w);
    end
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_w !== exp_v) begin n_fail++; $display("FAIL idle_sb: got %h want %h", obs_w, exp_v); end
      if (bus.hit_pulse || bus.score_pulse) pulse_seen = 1;
    end
    n_checks++;
    if (bus.state !== 2'd0 || bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236 || pulse_seen) begin
      n_fail++; $display("FAIL idle_hold: got %h pulse %0d want idle centre no pulse", obs_w, pulse_seen);
    end
  endtask

  task automatic test_serve();
    bus.paddleL_y = 10'd0; bus.paddleR_y = 10'd0;
    cycle(1'b0, 1'b1, 1'b0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_w !== exp_v) begin n_fail++; $display("FAIL start_sb: got %h want %h", obs_w, exp_v); end
    n_checks++;
    if (bus.state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", bus.state); end
    for (int i = 0; i < ST; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_w !== exp_v) begin n_fail++; $display("FAIL serve_sb: got %h want %h", obs_w, exp_v); end
      n_checks++;
      if (bus.state !== ((i == ST - 1) ? 2'd2 : 2'd1) || bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236) begin
        n_fail++; $display("FAIL serve_len: tick %0d got %h", i, obs_w);
      end
    end
    bus.paddleR_y = 10'd216;
    cycle(1'b1, 1'b0, 1'b0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_w !== exp_v) begin n_fail++; $display("FAIL first_move_sb: got %h want %h", obs_w, exp_v); end
    n_checks++;
    if (bus.ball_x !== 10'd317 || bus.ball_y !== 10'd239 || bus.state !== 2'd2) begin
      n_fail++; $display("FAIL first_move: got (%0d,%0d) want (317,239)", bus.ball_x, bus.ball_y);
    end
  endtask

  task automatic test_back_to_back();
    int dut_hits = 0, base = m_hits;
    for (int i = 0; i < 1500; i++) begin
      bus.paddleL_y = 10'((m_y >= 20) ? m_y - 20 : 0);
      bus.paddleR_y = 10'((m_y >= 20) ? m_y - 20 : 0);
      cycle((i < 800) ? 1'b1 : logic'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_w !== exp_v) begin n_fail++; $display("FAIL rally_sb: cyc %0d got %h want %h", i, obs_w, exp_v); end
      if (bus.hit_pulse) dut_hits++;
    end
    n_checks++;
    if (dut_hits !== m_hits - base || dut_hits < 2) begin
      n_fail++; $display("FAIL rally_hits: got %0d want %0d (>=2)", dut_hits, m_hits - base);
    end
  endtask

  task automatic test_miss();
    bit seen = 0;
    bus.paddleL_y = 10'd1000;
    for (int i = 0; i < 5000 && !seen; i++) begin
      bus.paddleR_y = 10'((m_y >= 20) ? m_y - 20 : 0);
      cycle(1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_w !== exp_v) begin n_fail++; $display("FAIL miss_sb: got %h want %h", obs_w, exp_v); end
      if (bus.score_pulse) seen = 1;
    end
    n_checks++;
    if (!seen || bus.scoreR !== 4'd1 || bus.scoreL !== 4'd0 || bus.state !== 2'd1 ||
        bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236) begin
      n_fail++; $display("FAIL left_miss: seen %0d got %h want scoreR 1 serve centre", seen, obs_w);
    end
    cycle(1'b0, 1'b0, 1'b0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_w !== exp_v || bus.score_pulse !== 1'b0) begin
      n_fail++; $display("FAIL pulse_len: got %h want %h", obs_w, exp_v);
    end
  endtask

  task automatic test_win();
    bus.paddleR_y = 10'd1000;
    for (int i = 0; i < 20000 && bus.state !== 2'd3; i++) begin
      bus.paddleL_y = 10'((m_y >= 20) ? m_y - 20 : 0);
      cycle(1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_w !== exp_v) begin n_fail++; $display("FAIL win_sb: got %h want %h", obs_w, exp_v); end
    end
    n_checks++;
    if (bus.state !== 2'd3 || bus.scoreL !== 4'd7 || bus.scoreR !== 4'd1 || bus.winner !== 2'd1) begin
      n_fail++; $display("FAIL game_over: got %h want state 3 scoreL 7 winner 1", obs_w);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_w !== exp_v) begin n_fail++; $display("FAIL over_hold: got %h want %h", obs_w, exp_v); end
    end
  endtask

  task automatic test_restart();
    cycle(1'b0, 1'b1, 1'b0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_w !== exp_v) begin n_fail++; $display("FAIL restart_sb: got %h want %h", obs_w, exp_v); end
    n_checks++;
    if (bus.state !== 2'd1 || bus.scoreL !== 4'd0 || bus.scoreR !== 4'd0 || bus.winner !== 2'd0) begin
      n_fail++; $display("FAIL restart: got %h want serve, scores 0", obs_w);
    end
  endtask

  task automatic test_reset_mid_play();
    bus.paddleL_y = 10'd0; bus.paddleR_y = 10'd0;
    for (int i = 0; i < ST + 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front(); n_checks++;
      if (obs_w !== exp_v) begin n_fail++; $display("FAIL pre_rst_sb: got %h want %h", obs_w, exp_v); end
    end
    n_checks++;
    if (bus.state !== 2'd2 || bus.ball_x === 10'd316) begin
      n_fail++; $display("FAIL pre_rst_play: got %h want moving in play", obs_w);
    end
    cycle(1'b1, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_w !== exp_v || bus.state !== 2'd0 || bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236) begin
      n_fail++; $display("FAIL mid_play_rst: got %h want %h", obs_w, exp_v);
    end
    cycle(1'b1, 1'b0, 1'b0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs_w !== exp_v) begin n_fail++; $display("FAIL post_rst_sb: got %h want %h", obs_w, exp_v); end
  endtask

  initial begin
    rst = 1'b1; bus.tick = 1'b0; bus.start = 1'b0;
    bus.paddleL_y = 10'd0; bus.paddleR_y = 10'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_serve();
    test_back_to_back();
    test_miss();
    test_win();
    test_restart();
    test_reset_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
